dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares one byte-addressed Data_Memory (MemWrite_i/MemRead_i/addr_i/data_i/data_o) between two requesters.
//  Port 0 is the CPU MEM stage; port 1 is the debug/loader port.
//  Round-robin arbitration, a req/ack handshake per port, and strictly exclusive memory strobes.
//  Word-aligned bounds checking is done before any access reaches the memory.
// PARAMETERS
//  MEM_BYTES      32  size of the attached memory in bytes; legal word addresses are 0..MEM_BYTES-4
//  ACCESS_CYCLES  1   cycles the strobe is held per access (>=1)
//  CNT_W          4   width of the access counter; must satisfy 2**CNT_W > ACCESS_CYCLES
// PORTS
//  clk_i        in   1   clock, rising edge
//  rst_i        in   1   asynchronous reset, active low
//  req0_i       in   1   port 0 request; held with we0_i/addr0_i/wdata0_i until ack0_o
//  we0_i        in   1   1 = write, 0 = read
//  addr0_i      in   32  byte address
//  wdata0_i     in   32  write data
//  ack0_o       out  1   one-cycle completion pulse
//  err0_o       out  1   valid with ack0_o; 1 = rejected (misaligned or out of range)
//  rdata0_o     out  32  read data; valid from ack0_o until the next port-0 read completes
//  req1_i, we1_i, addr1_i, wdata1_i, ack1_o, err1_o, rdata1_o   same as port 0, for port 1
//  mem_addr_o   out  32  to Data_Memory addr_i
//  mem_data_o   out  32  to Data_Memory data_i
//  mem_write_o  out  1   to Data_Memory MemWrite_i
//  mem_read_o   out  1   to Data_Memory MemRead_i
//  mem_data_i   in   32  from Data_Memory data_o
//  busy_o       out  1   1 whenever state != IDLE
// BEHAVIOUR
//  Reset (rst_i=0, asynchronous):
//   - All outputs are 0; state = IDLE; counter = 0.
//   - Round-robin pointer last = 1, so port 0 wins first.
//   - Reset in mid-operation aborts the access: strobes drop immediately and no ack is issued.
//  FSM states: IDLE, ACCESS, DONE.
//  IDLE:
//   - Grant goes to the requesting port. If both request, grant the port != last; then last <= granted port.
//   - Latch we/addr/wdata of the granted port.
//   - Legal = addr[1:0]==0 and addr <= MEM_BYTES-4. Legal -> ACCESS with cnt=0; illegal -> DONE with err set.
//  ACCESS:
//   - mem_addr_o/mem_data_o come from the latched request.
//   - Exactly one of mem_write_o (we=1) or mem_read_o (we=0) is high; cnt increments each cycle.
//   - On the edge where cnt==ACCESS_CYCLES-1: a read captures mem_data_i into rdata<g>_o; go to DONE.
//  DONE:
//   - ack<g>_o=1 for exactly this cycle; err<g>_o = the latched error flag.
//   - Strobes are 0; next state is IDLE.
//  Requester contract:
//   - Drop req on the edge that ends the ack cycle.
//   - A req still high in the following IDLE counts as a new request.
//  Latency:
//   - Request seen in IDLE at cycle N: ack at cycle N+ACCESS_CYCLES+1 (legal) or N+1 (error).
//   - Minimum spacing between back-to-back grants is ACCESS_CYCLES+2 cycles.
//  Side effects and data rules:
//   - Errors issue no strobe, so memory is untouched; rdata of the errored port is unchanged.
//   - Writes leave rdata unchanged.
//   - mem_addr_o/mem_data_o hold their last value outside ACCESS; only the strobes are guaranteed 0.
//   - Request inputs that change while not granted are ignored; the latched copy governs.
//   - mem_write_o and mem_read_o are never high together, and are never high outside ACCESS.
//   - ack0_o and ack1_o are never high together.
// TESTING
//  1 Reset: rst_i low mid-ACCESS -> strobes 0 at once, no ack; after release state IDLE and busy_o=0.
//  2 Port-0 write of 0xDEADBEEF @8, then port-0 read @8 (ACCESS_CYCLES=1):
//    ack 2 cycles after each req; rdata0_o=0xDEADBEEF, err0_o=0.
//  3 req0 and req1 both high from reset, each re-requesting after its ack:
//    grant order 0,1,0,1; no overlap between acks.
//  4 Port-1 read @6 (misaligned) and @32 (out of range): ack1_o after 1 cycle with err1_o=1;
//    mem_read_o never high; rdata1_o unchanged.
//  5 ACCESS_CYCLES=3, port-1 write 0x12345678 @28:
//    mem_write_o high 3 consecutive cycles; ack1_o at N+4; a port-0 read @28 then returns 0x12345678.
//  6 Port-0 request mid port-1 access: port 0 waits and is granted in the IDLE after ack1_o;
//    assertions check strobe exclusivity throughout.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one byte-addressed data memory between two requesters.
//   Port 0 is the CPU MEM stage, port 1 the debug/loader port. Round-robin grant,
//   req/ack handshake per port, word-aligned bounds check ahead of the memory, and
//   mutually exclusive memory strobes.
// Ports:
//   clk_i, rst_i                    clock (rising edge), asynchronous active-low reset
//   req<n>_i, we<n>_i               request / write-enable, held until ack<n>_o
//   addr<n>_i, wdata<n>_i           byte address and write data
//   ack<n>_o, err<n>_o, rdata<n>_o  completion pulse, reject flag, read data
//   mem_addr_o, mem_data_o          address / write data to the memory
//   mem_write_o, mem_read_o         memory strobes, never both high
//   mem_data_i                      read data from the memory
//   busy_o                          high whenever an access is in flight
module dmem_arbiter #(
    parameter int unsigned MEM_BYTES     = 32,
    parameter int unsigned ACCESS_CYCLES = 1,
    parameter int unsigned CNT_W         = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_i,
    input  logic        we0_i,
    input  logic [31:0] addr0_i,
    input  logic [31:0] wdata0_i,
    output logic        ack0_o,
    output logic        err0_o,
    output logic [31:0] rdata0_o,
    input  logic        req1_i,
    input  logic        we1_i,
    input  logic [31:0] addr1_i,
    input  logic [31:0] wdata1_i,
    output logic        ack1_o,
    output logic        err1_o,
    output logic [31:0] rdata1_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        mem_write_o,
    output logic        mem_read_o,
    input  logic [31:0] mem_data_i,
    output logic        busy_o
);

    localparam logic [31:0]      MaxAddr = 32'(MEM_BYTES - 4);
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e           state_q;
    logic             last_q;
    logic             gnt_q;
    logic [CNT_W-1:0] cnt_q;

    logic        req_any;
    logic        gnt_d;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        legal;

    // Grant selection: on contention the port that was not served last wins.
    always_comb begin
        req_any = req0_i | req1_i;
        if (req0_i && req1_i) begin
            gnt_d = ~last_q;
        end else begin
            gnt_d = req1_i;
        end
        sel_we    = gnt_d ? we1_i    : we0_i;
        sel_addr  = gnt_d ? addr1_i  : addr0_i;
        sel_wdata = gnt_d ? wdata1_i : wdata0_i;
        legal     = (sel_addr[1:0] == 2'b00) && (sel_addr <= MaxAddr);
    end

    // mem_addr_o/mem_data_o double as the latched request; they are only loaded for legal
    // grants, so a rejected request never disturbs the memory bus.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;
            gnt_q       <= 1'b0;
            cnt_q       <= '0;
            ack0_o      <= 1'b0;
            err0_o      <= 1'b0;
            rdata0_o    <= '0;
            ack1_o      <= 1'b0;
            err1_o      <= 1'b0;
            rdata1_o    <= '0;
            mem_addr_o  <= '0;
            mem_data_o  <= '0;
            mem_write_o <= 1'b0;
            mem_read_o  <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            ack0_o <= 1'b0;
            ack1_o <= 1'b0;
            err0_o <= 1'b0;
            err1_o <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_any) begin
                        last_q <= gnt_d;
                        gnt_q  <= gnt_d;
                        busy_o <= 1'b1;
                        if (legal) begin
                            mem_addr_o  <= sel_addr;
                            mem_data_o  <= sel_wdata;
                            mem_write_o <= sel_we;
                            mem_read_o  <= ~sel_we;
                            cnt_q       <= '0;
                            state_q     <= StAccess;
                        end else begin
                            // Rejected: straight to the ack cycle with the error flag.
                            ack0_o  <= ~gnt_d;
                            err0_o  <= ~gnt_d;
                            ack1_o  <= gnt_d;
                            err1_o  <= gnt_d;
                            state_q <= StDone;
                        end
                    end
                end
                StAccess: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        mem_write_o <= 1'b0;
                        mem_read_o  <= 1'b0;
                        if (mem_read_o) begin
                            if (gnt_q) begin
                                rdata1_o <= mem_data_i;
                            end else begin
                                rdata0_o <= mem_data_i;
                            end
                        end
                        ack0_o  <= ~gnt_q;
                        ack1_o  <= gnt_q;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    busy_o  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_o  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: two arbiter instances (ACCESS_CYCLES 1 and 3), each with its own
// behavioural memory, driven by directed and random transactions and compared against a
// transaction-level model of the arbitration, bounds and data rules.
module tb_dmem_arbiter;

    localparam int unsigned MemBytes = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // Requester inputs, indexed [instance][port].
    logic        req   [2][2];
    logic        we    [2][2];
    logic [31:0] addr  [2][2];
    logic [31:0] wdata [2][2];

    // DUT outputs, packed index 2*instance+port.
    logic [3:0]        ack_v;
    logic [3:0]        err_v;
    logic [3:0][31:0]  rdata_v;
    logic [1:0][31:0]  mem_addr_v;
    logic [1:0][31:0]  mem_wdata_v;
    logic [1:0][31:0]  mem_rdata_v;
    logic [1:0]        mem_write_v;
    logic [1:0]        mem_read_v;
    logic [1:0]        busy_v;

    // Memory attached to each instance.
    logic [31:0] dmem [2][8] = '{default: 32'h0};
    assign mem_rdata_v[0] = dmem[0][mem_addr_v[0][4:2]];
    assign mem_rdata_v[1] = dmem[1][mem_addr_v[1][4:2]];
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_write_v[i]) dmem[i][mem_addr_v[i][4:2]] <= mem_wdata_v[i];
        end
    end

    dmem_arbiter #(.MEM_BYTES(MemBytes), .ACCESS_CYCLES(1), .CNT_W(4)) u_dut_fast (
        .clk_i(clk), .rst_i(rst_n),
        .req0_i(req[0][0]), .we0_i(we[0][0]), .addr0_i(addr[0][0]), .wdata0_i(wdata[0][0]),
        .ack0_o(ack_v[0]), .err0_o(err_v[0]), .rdata0_o(rdata_v[0]),
        .req1_i(req[0][1]), .we1_i(we[0][1]), .addr1_i(addr[0][1]), .wdata1_i(wdata[0][1]),
        .ack1_o(ack_v[1]), .err1_o(err_v[1]), .rdata1_o(rdata_v[1]),
        .mem_addr_o(mem_addr_v[0]), .mem_data_o(mem_wdata_v[0]),
        .mem_write_o(mem_write_v[0]), .mem_read_o(mem_read_v[0]),
        .mem_data_i(mem_rdata_v[0]), .busy_o(busy_v[0])
    );

    dmem_arbiter #(.MEM_BYTES(MemBytes), .ACCESS_CYCLES(3), .CNT_W(4)) u_dut_slow (
        .clk_i(clk), .rst_i(rst_n),
        .req0_i(req[1][0]), .we0_i(we[1][0]), .addr0_i(addr[1][0]), .wdata0_i(wdata[1][0]),
        .ack0_o(ack_v[2]), .err0_o(err_v[2]), .rdata0_o(rdata_v[2]),
        .req1_i(req[1][1]), .we1_i(we[1][1]), .addr1_i(addr[1][1]), .wdata1_i(wdata[1][1]),
        .ack1_o(ack_v[3]), .err1_o(err_v[3]), .rdata1_o(rdata_v[3]),
        .mem_addr_o(mem_addr_v[1]), .mem_data_o(mem_wdata_v[1]),
        .mem_write_o(mem_write_v[1]), .mem_read_o(mem_read_v[1]),
        .mem_data_i(mem_rdata_v[1]), .busy_o(busy_v[1])
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    function automatic int ac_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic bit is_legal(input logic [31:0] a);
        return (a % 32'd4 == 32'd0) && (a + 32'd4 <= MemBytes);
    endfunction

    // Cycles from raising req in an idle arbiter to seeing ack.
    function automatic int lat_of(input int i, input bit e);
        return e ? 1 : ac_of(i) + 1;
    endfunction

    // Reference model: memory contents, visible rdata per port, round-robin pointer.
    logic [31:0] ref_mem   [2][8] = '{default: 32'h0};
    logic [31:0] exp_rdata [2][2] = '{default: 32'h0};
    int          last      [2]    = '{1, 1};

    task automatic model_apply(input int i, input int p, input bit w, input logic [31:0] a,
                               input logic [31:0] d, output bit e);
        int idx;
        e   = !is_legal(a);
        idx = int'(a / 32'd4);
        if (!e) begin
            if (w) ref_mem[i][idx] = d;
            else   exp_rdata[i][p] = ref_mem[i][idx];
        end
        last[i] = p;
    endtask

    // Bus monitor: strobe exclusivity, strobe run length, ack ordering.
    int run        [2] = '{0, 0};
    int strobe_cnt [2] = '{0, 0};
    int ack_n      [2] = '{0, 0};
    int ack_seq    [2][256];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                run[i] = 0;
            end else begin
                check($sformatf("strobe_excl[%0d]", i), 32'(mem_write_v[i] & mem_read_v[i]), 0);
                check($sformatf("strobe_idle[%0d]", i),
                      32'((mem_write_v[i] | mem_read_v[i]) & ~busy_v[i]), 0);
                check($sformatf("ack_excl[%0d]", i), 32'(ack_v[2*i] & ack_v[2*i+1]), 0);
                if (mem_write_v[i] | mem_read_v[i]) begin
                    run[i]++;
                    strobe_cnt[i]++;
                end else if (run[i] > 0) begin
                    check($sformatf("strobe_len[%0d]", i), 32'(run[i]), 32'(ac_of(i)));
                    run[i] = 0;
                end
                if (ack_v[2*i]) begin
                    ack_seq[i][ack_n[i] % 256] = 0;
                    ack_n[i]++;
                end
                if (ack_v[2*i+1]) begin
                    ack_seq[i][ack_n[i] % 256] = 1;
                    ack_n[i]++;
                end
            end
        end
    end

    // Results of the most recent transaction on each port.
    bit          res_done  [2][2];
    logic        res_err   [2][2];
    logic [31:0] res_rdata [2][2];
    int          res_lat   [2][2];

    // Drive one request (after skip extra cycles) and wait, bounded, for its ack.
    task automatic port_txn(input int i, input int p, input bit w, input logic [31:0] a,
                            input logic [31:0] d, input int skip);
        int k;
        k = 0;
        repeat (skip + 1) @(negedge clk);
        req[i][p]   = 1'b1;
        we[i][p]    = w;
        addr[i][p]  = a;
        wdata[i][p] = d;
        res_done[i][p] = 1'b0;
        while (!res_done[i][p] && k < 200) begin
            @(negedge clk);
            k++;
            if (ack_v[2*i+p]) begin
                res_done[i][p]  = 1'b1;
                res_err[i][p]   = err_v[2*i+p];
                res_rdata[i][p] = rdata_v[2*i+p];
                res_lat[i][p]   = k;
            end
        end
        req[i][p]   = 1'b0;
        addr[i][p]  = $urandom;
        wdata[i][p] = $urandom;
        check($sformatf("ack_seen[%0d.%0d]", i, p), 32'(res_done[i][p]), 1);
    endtask

    task automatic txn_single(input int i, input int p, input bit w, input logic [31:0] a,
                              input logic [31:0] d);
        int s0;
        bit e;
        s0 = strobe_cnt[i];
        port_txn(i, p, w, a, d, 0);
        #1;
        model_apply(i, p, w, a, d, e);
        check($sformatf("err[%0d.%0d]", i, p), 32'(res_err[i][p]), 32'(e));
        check($sformatf("rdata[%0d.%0d]", i, p), res_rdata[i][p], exp_rdata[i][p]);
        check($sformatf("rdata_other[%0d.%0d]", i, 1 - p), rdata_v[2*i+1-p], exp_rdata[i][1-p]);
        check($sformatf("latency[%0d.%0d]", i, p), 32'(res_lat[i][p]), 32'(lat_of(i, e)));
        check($sformatf("strobes[%0d.%0d]", i, p), 32'(strobe_cnt[i] - s0),
              32'(e ? 0 : ac_of(i)));
    endtask

    // Both ports request in the same cycle; the model decides who goes first.
    task automatic txn_pair(input int i, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                            input bit w1, input logic [31:0] a1, input logic [31:0] d1);
        int          first;
        int          second;
        int          n0;
        int          s0;
        bit          ws [2];
        logic [31:0] as [2];
        logic [31:0] ds [2];
        bit          es [2];
        ws = '{w0, w1};
        as = '{a0, a1};
        ds = '{d0, d1};
        first  = (last[i] == 0) ? 1 : 0;
        second = 1 - first;
        n0 = ack_n[i];
        s0 = strobe_cnt[i];
        fork
            port_txn(i, 0, w0, a0, d0, 0);
            port_txn(i, 1, w1, a1, d1, 0);
        join
        #1;
        model_apply(i, first, ws[first], as[first], ds[first], es[first]);
        model_apply(i, second, ws[second], as[second], ds[second], es[second]);
        for (int q = 0; q < 2; q++) begin
            check($sformatf("pair_err[%0d.%0d]", i, q), 32'(res_err[i][q]), 32'(es[q]));
            check($sformatf("pair_rdata[%0d.%0d]", i, q), res_rdata[i][q], exp_rdata[i][q]);
        end
        check($sformatf("pair_acks[%0d]", i), 32'(ack_n[i] - n0), 2);
        check($sformatf("pair_first[%0d]", i), 32'(ack_seq[i][n0 % 256]), 32'(first));
        check($sformatf("pair_lat1[%0d]", i), 32'(res_lat[i][first]), 32'(lat_of(i, es[first])));
        check($sformatf("pair_lat2[%0d]", i), 32'(res_lat[i][second]),
              32'(lat_of(i, es[first]) + 1 + lat_of(i, es[second])));
        check($sformatf("pair_strobes[%0d]", i), 32'(strobe_cnt[i] - s0),
              32'((es[0] ? 0 : ac_of(i)) + (es[1] ? 0 : ac_of(i))));
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 9)) * 32'd4;
        if ($urandom_range(0, 4) == 0) a = a + 32'($urandom_range(1, 3));
        return a;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int n0;
        bit e;
        int k;
        bit seen;
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) begin
                req[i][p]   = 1'b0;
                we[i][p]    = 1'b0;
                addr[i][p]  = '0;
                wdata[i][p] = '0;
            end
        end

        // Reset values.
        #1 rst_n = 1'b0;
        #3;
        check("rst_ack", 32'(ack_v), 0);
        check("rst_err", 32'(err_v), 0);
        check("rst_busy", 32'(busy_v), 0);
        check("rst_strobes", 32'({mem_write_v, mem_read_v}), 0);
        for (int q = 0; q < 4; q++) check($sformatf("rst_rdata[%0d]", q), rdata_v[q], 0);
        check("rst_maddr0", mem_addr_v[0], 0);
        check("rst_mdata1", mem_wdata_v[1], 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Both ports requesting from reset, re-requesting after each ack: 0,1,0,1.
        n0 = ack_n[0];
        fork
            begin
                port_txn(0, 0, 1'b1, 32'd0, 32'h1111_0000, 0);
                port_txn(0, 0, 1'b0, 32'd4, 32'h0, 0);
            end
            begin
                port_txn(0, 1, 1'b1, 32'd4, 32'h2222_0000, 0);
                port_txn(0, 1, 1'b0, 32'd0, 32'h0, 0);
            end
        join
        #1;
        model_apply(0, 0, 1'b1, 32'd0, 32'h1111_0000, e);
        model_apply(0, 1, 1'b1, 32'd4, 32'h2222_0000, e);
        model_apply(0, 0, 1'b0, 32'd4, 32'h0, e);
        model_apply(0, 1, 1'b0, 32'd0, 32'h0, e);
        check("rr_count", 32'(ack_n[0] - n0), 4);
        for (int q = 0; q < 4; q++) begin
            check($sformatf("rr_order[%0d]", q), 32'(ack_seq[0][(n0 + q) % 256]), 32'(q % 2));
        end
        check("rr_rdata0", res_rdata[0][0], exp_rdata[0][0]);
        check("rr_rdata1", res_rdata[0][1], exp_rdata[0][1]);

        // Port-0 write then read at 8.
        txn_single(0, 0, 1'b1, 32'd8, 32'hDEAD_BEEF);
        txn_single(0, 0, 1'b0, 32'd8, 32'h0);
        check("wr_rd_8", res_rdata[0][0], 32'hDEAD_BEEF);

        // Port-1 rejected reads: misaligned and out of range.
        txn_single(0, 1, 1'b0, 32'd6, 32'h0);
        txn_single(0, 1, 1'b0, 32'd32, 32'h0);

        // Three-cycle access: port-1 write at the top word, port-0 reads it back.
        txn_single(1, 1, 1'b1, 32'd28, 32'h1234_5678);
        txn_single(1, 0, 1'b0, 32'd28, 32'h0);
        check("slow_rd_28", res_rdata[1][0], 32'h1234_5678);

        // Port 0 arrives while port 1 is mid-access and must wait for the next idle.
        n0 = ack_n[1];
        fork
            port_txn(1, 1, 1'b1, 32'd16, 32'hA5A5_0F0F, 0);
            port_txn(1, 0, 1'b0, 32'd16, 32'h0, 2);
        join
        #1;
        model_apply(1, 1, 1'b1, 32'd16, 32'hA5A5_0F0F, e);
        model_apply(1, 0, 1'b0, 32'd16, 32'h0, e);
        check("late_lat1", 32'(res_lat[1][1]), 32'(ac_of(1) + 1));
        check("late_lat0", 32'(res_lat[1][0]), 32'((ac_of(1) + 1) + 1 + (ac_of(1) + 1) - 2));
        check("late_order", 32'(ack_seq[1][n0 % 256]), 1);
        check("late_rdata", res_rdata[1][0], exp_rdata[1][0]);

        // Reset during an access: strobes drop at once and no ack follows.
        @(negedge clk);
        req[1][0]  = 1'b1;
        we[1][0]   = 1'b0;
        addr[1][0] = 32'd12;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 10) begin
            @(negedge clk);
            k++;
            seen = mem_read_v[1];
        end
        check("mid_access_reached", 32'(seen), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_strobes", 32'({mem_write_v, mem_read_v}), 0);
        check("mid_rst_ack", 32'(ack_v), 0);
        check("mid_rst_busy", 32'(busy_v), 0);
        req[1][0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("post_rst_busy[%0d]", c), 32'(busy_v[1]), 0);
            check($sformatf("post_rst_ack[%0d]", c), 32'(ack_v[3:2]), 0);
        end
        last      = '{1, 1};
        exp_rdata = '{default: 32'h0};

        // Random traffic on both instances.
        for (int t = 0; t < 40; t++) begin
            int i;
            int kind;
            i    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 2));
            if (kind == 2) begin
                txn_pair(i, 1'($urandom_range(0, 1)), rand_addr(), $urandom,
                            1'($urandom_range(0, 1)), rand_addr(), $urandom);
            end else begin
                txn_single(i, kind, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            end
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
